// File: rtl/soc_system_pio_master.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pio_master
//  Description : Avalon-MM master for PIO-style register slaves. Takes one
//                command at a time (READ, WRITE, SET, CLEAR, TOGGLE), turns
//                it into a chipselect-qualified slave access with a fixed
//                read latency, and returns the result on a response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_pio_master #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1    // legal range 1..4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_readdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] av_address,
   output logic              av_chipselect,
   output logic              av_write_n,
   output logic [DATA_W-1:0] av_writedata,
   input  logic [DATA_W-1:0] av_readdata
);

   localparam logic [2:0] c_OP_READ   = 3'd0;
   localparam logic [2:0] c_OP_WRITE  = 3'd1;
   localparam logic [2:0] c_OP_SET    = 3'd2;
   localparam logic [2:0] c_OP_CLEAR  = 3'd3;
   localparam logic [2:0] c_OP_TOGGLE = 3'd4;
   // RD lasts READ_LATENCY+1 cycles: the counter starts at READ_LATENCY and
   // the read data is captured on the edge where it has reached zero.
   localparam logic [2:0] c_RD_WAIT   = 3'(READ_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] av_address_q, av_address_d;
   logic              av_chipselect_q, av_chipselect_d;
   logic              av_write_n_q, av_write_n_d;
   logic [DATA_W-1:0] av_writedata_q, av_writedata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_readdata_q, rsp_readdata_d;
   logic              rsp_error_q, rsp_error_d;

   // Bitwise modify step of the read-modify-write operations.
   function automatic logic [DATA_W-1:0] f_modify(input logic [2:0]        op,
                                                  input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] mask);
      logic [DATA_W-1:0] result;
      case (op)
         c_OP_SET:    result = old | mask;
         c_OP_CLEAR:  result = old & ~mask;
         c_OP_TOGGLE: result = old ^ mask;
         default:     result = old;
      endcase
      return result;
   endfunction

   // Next-state logic; bus and response strobes are decoded from the next
   // state so that they appear registered in the same cycle as the state.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op_d           = op_q;
      data_d         = data_q;
      av_address_d   = av_address_q;
      av_writedata_d = av_writedata_q;
      rsp_readdata_d = rsp_readdata_q;
      rsp_error_d    = rsp_error_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               case (cmd_op)
                  c_OP_READ, c_OP_SET, c_OP_CLEAR, c_OP_TOGGLE: begin
                     state_d      = S_RD;
                     cnt_d        = c_RD_WAIT;
                     av_address_d = cmd_address;
                     rsp_error_d  = 1'b0;
                  end
                  c_OP_WRITE: begin
                     state_d        = S_WR;
                     av_address_d   = cmd_address;
                     av_writedata_d = cmd_data;
                     rsp_readdata_d = '0;
                     rsp_error_d    = 1'b0;
                  end
                  default: begin
                     // Illegal opcode: answer immediately, never touch the bus.
                     state_d        = S_RESP;
                     rsp_readdata_d = '0;
                     rsp_error_d    = 1'b1;
                  end
               endcase
            end
         end
         S_RD: begin
            if (cnt_q == 3'd0) begin
               rsp_readdata_d = av_readdata;
               if (op_q == c_OP_READ) begin
                  state_d = S_RESP;
               end else begin
                  state_d        = S_WR;
                  av_writedata_d = f_modify(op_q, av_readdata, data_q);
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_WR: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      av_chipselect_d = (state_d == S_RD) || (state_d == S_WR);
      av_write_n_d    = (state_d != S_WR);
      rsp_valid_d     = (state_d == S_RESP);
   end

   // State and output registers; reset drops any command in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= 3'd0;
         op_q            <= 3'd0;
         data_q          <= '0;
         av_address_q    <= '0;
         av_chipselect_q <= 1'b0;
         av_write_n_q    <= 1'b1;
         av_writedata_q  <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_readdata_q  <= '0;
         rsp_error_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         op_q            <= op_d;
         data_q          <= data_d;
         av_address_q    <= av_address_d;
         av_chipselect_q <= av_chipselect_d;
         av_write_n_q    <= av_write_n_d;
         av_writedata_q  <= av_writedata_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_readdata_q  <= rsp_readdata_d;
         rsp_error_q     <= rsp_error_d;
      end
   end

   assign cmd_ready     = (state_q == S_IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_readdata  = rsp_readdata_q;
   assign rsp_error     = rsp_error_q;
   assign av_address    = av_address_q;
   assign av_chipselect = av_chipselect_q;
   assign av_write_n    = av_write_n_q;
   assign av_writedata  = av_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_pio_master
//  Description : Bench for soc_system_pio_master. Two instances (read latency
//                1 and 3) each drive a behavioural register slave; results
//                are checked against a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_pio_master;

   typedef struct packed {
      int          first_rsp;   // cycle (after accept) where rsp_valid rises
      int          cs_cnt;      // cycles with chipselect high
      int          cs_first;    // first chipselect cycle
      int          strobe_cnt;  // cycles with write strobe low
      int          strobe_cyc;  // cycle of the write strobe
      logic [31:0] strobe_data;
      logic [31:0] rdata;
      logic        err;
      logic        bad;         // protocol violation / timeout / instability
   } obs_t;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid    [2];
   logic        cmd_ready    [2];
   logic [2:0]  cmd_op       [2];
   logic [1:0]  cmd_address  [2];
   logic [31:0] cmd_data     [2];
   logic        rsp_valid    [2];
   logic        rsp_ready    [2];
   logic [31:0] rsp_readdata [2];
   logic        rsp_error    [2];
   logic [1:0]  av_address   [2];
   logic        av_chipselect[2];
   logic        av_write_n   [2];
   logic [31:0] av_writedata [2];
   logic [31:0] av_readdata  [2];

   logic [31:0] smem    [2][4];   // slave registers
   logic [31:0] pipe    [2][4];   // slave read pipeline
   int          strobes [2];      // write strobes seen by each slave
   logic [31:0] ref_mem [2][4];   // reference model register contents

   int n_checks = 0;
   int n_fail   = 0;

   soc_system_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
      .cmd_address(cmd_address[0]), .cmd_data(cmd_data[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_readdata(rsp_readdata[0]), .rsp_error(rsp_error[0]),
      .av_address(av_address[0]), .av_chipselect(av_chipselect[0]),
      .av_write_n(av_write_n[0]), .av_writedata(av_writedata[0]),
      .av_readdata(av_readdata[0]));

   soc_system_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(3)) u_dut_l3 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
      .cmd_address(cmd_address[1]), .cmd_data(cmd_data[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_readdata(rsp_readdata[1]), .rsp_error(rsp_error[1]),
      .av_address(av_address[1]), .av_chipselect(av_chipselect[1]),
      .av_write_n(av_write_n[1]), .av_writedata(av_writedata[1]),
      .av_readdata(av_readdata[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register slaves: register 0 powers up at 15, read data is registered
   // and delayed to give latency 1 (instance 0) or 3 (instance 1).
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) begin
            for (int r = 0; r < 4; r++) smem[d][r] <= (r == 0) ? 32'd15 : 32'd0;
         end else if (av_chipselect[d] && !av_write_n[d]) begin
            smem[d][av_address[d]] <= av_writedata[d];
         end
         if (av_chipselect[d] && !av_write_n[d]) strobes[d] <= strobes[d] + 1;
         pipe[d][0] <= smem[d][av_address[d]];
         for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
      end
   end
   assign av_readdata[0] = pipe[0][0];
   assign av_readdata[1] = pipe[1][2];

   function automatic string fmt(input obs_t o);
      return $sformatf("rsp@%0d cs=%0d from %0d wr=%0d@%0d wd=%h rd=%h err=%b bad=%b",
                       o.first_rsp, o.cs_cnt, o.cs_first, o.strobe_cnt, o.strobe_cyc,
                       o.strobe_data, o.rdata, o.err, o.bad);
   endfunction

   function automatic void reset_ref();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 4; r++) ref_mem[d][r] = (r == 0) ? 32'd15 : 32'd0;
   endfunction

   // Command-level reference: expected timing and result from the op rules.
   function automatic obs_t model(input int d, input logic [2:0] op,
                                  input logic [1:0] addr, input logic [31:0] data);
      obs_t        e;
      int          lat;
      logic [31:0] old, nv;
      e   = '0;
      lat = (d == 0) ? 1 : 3;
      old = ref_mem[d][addr];
      case (op)
         3'd0: begin
            e.first_rsp = lat + 2; e.cs_cnt = lat + 1; e.cs_first = 1; e.rdata = old;
         end
         3'd1: begin
            e.first_rsp = 2; e.cs_cnt = 1; e.cs_first = 1;
            e.strobe_cnt = 1; e.strobe_cyc = 1; e.strobe_data = data;
            ref_mem[d][addr] = data;
         end
         3'd2, 3'd3, 3'd4: begin
            nv = (op == 3'd2) ? (old | data) : (op == 3'd3) ? (old & ~data) : (old ^ data);
            e.first_rsp = lat + 3; e.cs_cnt = lat + 2; e.cs_first = 1;
            e.strobe_cnt = 1; e.strobe_cyc = lat + 2; e.strobe_data = nv;
            e.rdata = old;
            ref_mem[d][addr] = nv;
         end
         default: begin
            e.first_rsp = 1; e.err = 1'b1;
         end
      endcase
      return e;
   endfunction

   // Issue one command, observe bus/response cycle by cycle, optionally hold
   // rsp_ready low for 'hold' cycles, then consume the response.
   task automatic do_cmd(input int d, input logic [2:0] op, input logic [1:0] addr,
                         input logic [31:0] data, input int hold, input bit keep_valid,
                         output obs_t o);
      int t;
      o = '0;
      rsp_ready[d] = (hold == 0);
      @(negedge clk);
      cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_address[d] = addr; cmd_data[d] = data;
      t = 0;
      while (cmd_ready[d] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) o.bad = 1'b1;
      @(posedge clk); #1;
      if (keep_valid) cmd_op[d] = 3'd0;
      else begin cmd_valid[d] = 1'b0; cmd_op[d] = 3'($urandom); end
      cmd_address[d] = 2'($urandom);
      cmd_data[d]    = $urandom;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (av_chipselect[d]) begin
            o.cs_cnt++;
            if (o.cs_first == 0) o.cs_first = k;
            if (av_address[d] !== addr) o.bad = 1'b1;
         end
         if (!av_write_n[d]) begin
            o.strobe_cnt++; o.strobe_cyc = k; o.strobe_data = av_writedata[d];
         end
         if (rsp_valid[d] && cmd_ready[d]) o.bad = 1'b1;
         if (rsp_valid[d]) begin
            o.first_rsp = k; o.rdata = rsp_readdata[d]; o.err = rsp_error[d];
            break;
         end
      end
      if (o.first_rsp == 0) o.bad = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (rsp_valid[d] !== 1'b1 || rsp_readdata[d] !== o.rdata || rsp_error[d] !== o.err ||
             cmd_ready[d] !== 1'b0 || av_chipselect[d] !== 1'b0 || av_write_n[d] !== 1'b1)
            o.bad = 1'b1;
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1) o.bad = 1'b1;
   endtask

   task automatic test_reset();
      int   base;
      logic [71:0] got;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         got = {cmd_ready[d], rsp_valid[d], rsp_error[d], av_chipselect[d], av_write_n[d],
                rsp_readdata[d], av_address[d], av_writedata[d], 1'b0};
         n_checks++;
         if (got !== {5'b10001, 32'd0, 2'd0, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_values dut%0d: got %h required %h", d, got,
                               {5'b10001, 32'd0, 2'd0, 32'd0, 1'b0});
         end
      end
      // Start a SET on instance 0 and reset it while the read is in progress.
      base = strobes[0];
      cmd_valid[0] = 1'b1; cmd_op[0] = 3'd2; cmd_address[0] = 2'd0; cmd_data[0] = 32'hF0;
      @(posedge clk); #1 cmd_valid[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (av_chipselect[0] !== 1'b1) begin
         n_fail++; $display("FAIL rmw_started: chipselect %b required 1", av_chipselect[0]);
      end
      reset_n = 1'b0;
      #1;
      got = {cmd_ready[0], rsp_valid[0], rsp_error[0], av_chipselect[0], av_write_n[0],
             rsp_readdata[0], av_address[0], av_writedata[0], 1'b0};
      n_checks++;
      if (got !== {5'b10001, 32'd0, 2'd0, 32'd0, 1'b0}) begin
         n_fail++; $display("FAIL reset_mid_rmw: got %h required %h", got,
                            {5'b10001, 32'd0, 2'd0, 32'd0, 1'b0});
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (strobes[0] !== base || cmd_ready[0] !== 1'b1) begin
         n_fail++; $display("FAIL reset_no_write: strobes %0d ready %b required %0d ready 1",
                            strobes[0], cmd_ready[0], base);
      end
      reset_ref();
      n_checks++;
      if (smem[0][0] !== ref_mem[0][0]) begin
         n_fail++; $display("FAIL reset_pio_value: %h required %h", smem[0][0], ref_mem[0][0]);
      end
   endtask

   task automatic test_write();
      obs_t o, e;
      e = model(0, 3'd1, 2'd0, 32'h5);
      do_cmd(0, 3'd1, 2'd0, 32'h5, 0, 1'b0, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL write: got %s required %s", fmt(o), fmt(e)); end
      n_checks++;
      if (o.strobe_cyc != 1 || o.strobe_data !== 32'h5 || o.first_rsp != 2 ||
          o.rdata !== 32'h0 || o.err !== 1'b0) begin
         n_fail++; $display("FAIL write_plan: got %s required strobe@1 wd=5 rsp@2 rd=0", fmt(o));
      end
      n_checks++;
      if (smem[0][0] !== 32'h5) begin
         n_fail++; $display("FAIL write_pio: out_port %h required 00000005", smem[0][0]);
      end
   endtask

   task automatic test_read();
      obs_t o, e;
      for (int d = 0; d < 2; d++) begin
         e = model(d, 3'd1, 2'd0, 32'hA);
         do_cmd(d, 3'd1, 2'd0, 32'hA, 0, 1'b0, o);
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL read_setup dut%0d: got %s required %s", d, fmt(o), fmt(e)); end
         e = model(d, 3'd0, 2'd0, 32'h0);
         do_cmd(d, 3'd0, 2'd0, 32'h0, 0, 1'b0, o);
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL read dut%0d: got %s required %s", d, fmt(o), fmt(e)); end
         n_checks++;
         if (o.rdata !== 32'hA || o.first_rsp != ((d == 0) ? 3 : 5) || o.cs_cnt != ((d == 0) ? 2 : 4)) begin
            n_fail++; $display("FAIL read_plan dut%0d: got %s required rd=a rsp@%0d", d, fmt(o), (d == 0) ? 3 : 5);
         end
      end
   endtask

   task automatic test_rmw();
      obs_t        o, e;
      logic [2:0]  ops  [3] = '{3'd2, 3'd3, 3'd4};
      logic [31:0] mask [3] = '{32'h2, 32'h4, 32'hF};
      logic [31:0] wr   [3] = '{32'h7, 32'h3, 32'hC};
      logic [31:0] rd   [3] = '{32'h5, 32'h7, 32'h3};
      e = model(0, 3'd1, 2'd0, 32'h5);
      do_cmd(0, 3'd1, 2'd0, 32'h5, 0, 1'b0, o);
      for (int i = 0; i < 3; i++) begin
         e = model(0, ops[i], 2'd0, mask[i]);
         do_cmd(0, ops[i], 2'd0, mask[i], 0, 1'b0, o);
         n_checks++;
         if (o !== e || o.strobe_data !== wr[i] || o.rdata !== rd[i]) begin
            n_fail++; $display("FAIL rmw op%0d: got %s required wd=%h rd=%h (%s)", ops[i], fmt(o), wr[i], rd[i], fmt(e));
         end
      end
      n_checks++;
      if (smem[0][0] !== 32'hC) begin
         n_fail++; $display("FAIL rmw_pio: out_port %h required 0000000c", smem[0][0]);
      end
   endtask

   task automatic test_illegal();
      obs_t o, e;
      e = model(0, 3'd6, 2'd1, 32'h1234);
      do_cmd(0, 3'd6, 2'd1, 32'h1234, 0, 1'b0, o);
      n_checks++;
      if (o !== e || o.err !== 1'b1 || o.first_rsp != 1 || o.cs_cnt != 0 || o.rdata !== 32'd0) begin
         n_fail++; $display("FAIL illegal: got %s required %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_backpressure();
      obs_t       o, e;
      logic [1:0] a;
      int         first;
      bit         cs1;
      e = model(0, 3'd4, 2'd3, 32'h00FF00FF);
      do_cmd(0, 3'd4, 2'd3, 32'h00FF00FF, 10, 1'b1, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL hold_rsp: got %s required %s", fmt(o), fmt(e)); end
      // The pending READ (still valid) must be taken at the very next edge.
      a = cmd_address[0];
      e = model(0, 3'd0, a, 32'h0);
      @(posedge clk); #1 cmd_valid[0] = 1'b0;
      first = 0; cs1 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) cs1 = av_chipselect[0];
         if (rsp_valid[0]) begin first = k; break; end
      end
      n_checks++;
      if (cs1 !== 1'b1 || first != e.first_rsp || rsp_readdata[0] !== e.rdata) begin
         n_fail++; $display("FAIL accept_after_release: cs1=%b rsp@%0d rd=%h required cs1=1 rsp@%0d rd=%h",
                            cs1, first, rsp_readdata[0], e.first_rsp, e.rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int accepts, overlap, base;
      base = strobes[0]; accepts = 0; overlap = 0;
      @(negedge clk);
      cmd_valid[0] = 1'b1; cmd_op[0] = 3'd1; cmd_address[0] = 2'd2; cmd_data[0] = 32'h1234;
      for (int i = 0; i < 30; i++) begin
         if (cmd_ready[0]) accepts++;
         if (cmd_ready[0] && rsp_valid[0]) overlap++;
         @(negedge clk);
      end
      cmd_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      ref_mem[0][2] = 32'h1234;
      n_checks++;
      if (accepts != 10 || overlap != 0 || strobes[0] - base != 10) begin
         n_fail++; $display("FAIL b2b_write: accepts %0d overlap %0d strobes %0d required 10 0 10",
                            accepts, overlap, strobes[0] - base);
      end
      accepts = 0; overlap = 0;
      cmd_valid[0] = 1'b1; cmd_op[0] = 3'd0;
      for (int i = 0; i < 32; i++) begin
         if (cmd_ready[0]) accepts++;
         if (cmd_ready[0] && rsp_valid[0]) overlap++;
         @(negedge clk);
      end
      cmd_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (accepts != 8 || overlap != 0 || rsp_readdata[0] !== 32'h1234) begin
         n_fail++; $display("FAIL b2b_read: accepts %0d overlap %0d rd %h required 8 0 00001234",
                            accepts, overlap, rsp_readdata[0]);
      end
   endtask

   task automatic test_random();
      obs_t        o, e;
      logic [2:0]  op;
      logic [1:0]  a;
      logic [31:0] dt;
      int          hold;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 30; n++) begin
            op   = 3'($urandom_range(0, 7));
            a    = 2'($urandom);
            dt   = $urandom;
            hold = $urandom_range(0, 3);
            e = model(d, op, a, dt);
            do_cmd(d, op, a, dt, hold, 1'b0, o);
            n_checks++;
            if (o !== e) begin
               n_fail++; $display("FAIL random dut%0d #%0d op%0d: got %s required %s", d, n, op, fmt(o), fmt(e));
            end
            n_checks++;
            if (smem[d][a] !== ref_mem[d][a]) begin
               n_fail++; $display("FAIL random_mem dut%0d #%0d: reg%0d %h required %h", d, n, a, smem[d][a], ref_mem[d][a]);
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0; cmd_op[d] = 3'd0; cmd_address[d] = 2'd0;
         cmd_data[d] = 32'd0; rsp_ready[d] = 1'b1;
      end
      reset_ref();
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_rmw();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
